// File: rtl/pipe_pkg.sv
// Shared types and default widths for pipeline stage registers.
package pipe_pkg;

    localparam int unsigned WORD_LEN        = 32;
    localparam int unsigned INSTRUCTION_LEN = 32;

    // ALU result + memory data + instruction
    localparam int unsigned DEF_DATA_W = 3 * WORD_LEN;

    // Occupancy of a stage: nothing, main only, or main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with increment enable; holds at all-ones.
module pipe_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    // Count enabled cycles, stopping at the maximum value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and bubble gating of the control bits.
// Optional macro PIPE_STAGE_PERF_EN adds stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CTRL_W = 3
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    stage_state_e      state_q, state_d;
    logic              in_ready_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic              load_main_in, load_main_skid, load_skid;

    // Next-state and register load selection; flush overrides everything
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Payloads stay put; only occupancy is cleared
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        state_d      = FULL;
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            load_main_in = 1'b1;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (in_valid) begin
                        state_d   = SKID;
                        load_skid = 1'b1;
                    end
                end
                SKID: begin
                    // Upstream is blocked here, so in_valid is ignored
                    if (out_ready) begin
                        state_d        = FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State register; in_ready is its own flop so it never depends on out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID);
        end
    end

    // Main entry register: loads from upstream or drains from skid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else if (load_main_in) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
        end else if (load_main_skid) begin
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
        end
    end

    // Skid entry register: captures the entry accepted while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else if (load_skid) begin
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
        end
    end

    // Outputs; control is gated so a bubble never writes anything downstream
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q != EMPTY);
        out_data  = main_data_q;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .en (out_valid & ~out_ready),
        .cnt(stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .rst(rst),
        .en (~out_valid),
        .cnt(bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Define PIPE_STAGE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 96;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]    stall_cnt;
    logic [3:0]    bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_reg #(
        .DATA_W(DW),
        .CTRL_W(CW),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
    );
`else
    pipe_stage_reg #(
        .DATA_W(DW),
        .CTRL_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl)
    );
`endif

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got %h want 0", out_data);
        end
        checks++;
        if (out_ctrl !== 3'b000) begin
            errors++; $display("FAIL reset_out_ctrl got %b want 000", out_ctrl);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 96'hA5; in_ctrl = 3'b101; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_ctrl} !== {1'b1, 96'hA5, 3'b101}) begin
            errors++;
            $display("FAIL single_out got v=%b d=%h c=%b want v=1 d=a5 c=101",
                     out_valid, out_data, out_ctrl);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL single_in_ready got %b want 1", in_ready);
        end
        step();
        checks++;
        if ({out_valid, out_ctrl} !== {1'b0, 3'b000}) begin
            errors++;
            $display("FAIL single_drain got v=%b c=%b want v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_skid();
        do_reset();
        in_valid = 1'b1; in_data = 96'hD1; in_ctrl = 3'b001; out_ready = 1'b1;
        step();
        in_data = 96'hD2; in_ctrl = 3'b010; out_ready = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 96'hD1}) begin
            errors++;
            $display("FAIL skid_enter got rdy=%b v=%b d=%h want rdy=0 v=1 d=d1",
                     in_ready, out_valid, out_data);
        end
        // D3 waits upstream while the stage is full
        in_data = 96'hD3; in_ctrl = 3'b100;
        step();
        checks++;
        if ({in_ready, out_data, out_ctrl} !== {1'b0, 96'hD1, 3'b001}) begin
            errors++;
            $display("FAIL skid_hold got rdy=%b d=%h c=%b want rdy=0 d=d1 c=001",
                     in_ready, out_data, out_ctrl);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid, out_data, out_ctrl} !== {1'b1, 1'b1, 96'hD2, 3'b010}) begin
            errors++;
            $display("FAIL skid_drain_d2 got rdy=%b v=%b d=%h c=%b want rdy=1 v=1 d=d2 c=010",
                     in_ready, out_valid, out_data, out_ctrl);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_data, out_ctrl} !== {1'b1, 96'hD3, 3'b100}) begin
            errors++;
            $display("FAIL skid_drain_d3 got v=%b d=%h c=%b want v=1 d=d3 c=100",
                     out_valid, out_data, out_ctrl);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL skid_empty got v=%b want 0 (duplicate entry)", out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 96'h1234; in_ctrl = 3'b111; out_ready = 1'b0;
        step();
        checks++;
        if ({out_valid, out_ctrl} !== {1'b1, 3'b111}) begin
            errors++;
            $display("FAIL flush_pre got v=%b c=%b want v=1 c=111", out_valid, out_ctrl);
        end
        flush = 1'b1; in_data = 96'h77; in_ctrl = 3'b010;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, out_ctrl, in_ready} !== {1'b0, 3'b000, 1'b1}) begin
            errors++;
            $display("FAIL flush_out got v=%b c=%b rdy=%b want v=0 c=000 rdy=1",
                     out_valid, out_ctrl, in_ready);
        end
        checks++;
        if (out_data !== 96'h1234) begin
            errors++; $display("FAIL flush_payload got %h want 1234", out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_ctrl} !== {1'b0, 3'b000}) begin
            errors++;
            $display("FAIL flush_discard got v=%b c=%b want v=0 c=000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_async_rst();
        do_reset();
        in_valid = 1'b1; in_data = 96'hBEEF; in_ctrl = 3'b011; out_ready = 1'b0;
        step();
        in_data = 96'hCAFE; in_ctrl = 3'b110;
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_pre_skid got rdy=%b want 0", in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b0, 3'b000, 96'h0, 1'b1}) begin
            errors++;
            $display("FAIL arst_immediate got v=%b c=%b d=%h rdy=%b want v=0 c=000 d=0 rdy=1",
                     out_valid, out_ctrl, out_data, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if ({stall_cnt, bubble_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL perf_reset got s=%0d b=%0d want 0 0", stall_cnt, bubble_cnt);
        end
        repeat (5) step();
        checks++;
        if ({stall_cnt, bubble_cnt} !== {4'd0, 4'd5}) begin
            errors++;
            $display("FAIL perf_bubble got s=%0d b=%0d want 0 5", stall_cnt, bubble_cnt);
        end
        // Loading edge still sees an empty stage: one more bubble
        in_valid = 1'b1; in_data = 96'h5; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        checks++;
        if ({stall_cnt, bubble_cnt} !== {4'd15, 4'd6}) begin
            errors++;
            $display("FAIL perf_stall_sat got s=%0d b=%0d want 15 6", stall_cnt, bubble_cnt);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if ({stall_cnt, bubble_cnt} !== {4'd15, 4'd6}) begin
            errors++;
            $display("FAIL perf_flush got s=%0d b=%0d want 15 6", stall_cnt, bubble_cnt);
        end
        repeat (2) step();
        checks++;
        if (bubble_cnt !== 4'd8) begin
            errors++; $display("FAIL perf_after_flush got b=%0d want 8", bubble_cnt);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        int            bad = 0;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = {$urandom, $urandom, $urandom};
            c = CW'($urandom_range(0, 7));
            in_data = d;
            in_ctrl = c;
            step();
            checks++;
            if ({out_valid, out_data, out_ctrl, in_ready} !== {1'b1, d, c, 1'b1}) begin
                errors++;
                if (bad < 5) begin
                    $display("FAIL b2b_%0d got v=%b d=%h c=%b rdy=%b want v=1 d=%h c=%b rdy=1",
                             i, out_valid, out_data, out_ctrl, in_ready, d, c);
                end
                bad++;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid();
        test_flush();
        test_async_rst();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
